// File: rtl/bcd_timer_n.sv
// bcd_timer_n: a run/pause BCD timer that counts up or down between 0 and MAX_VAL.
// A prescaler produces one count step every DIV clock cycles spent in RUN.
//
// Parameters
//   DIGITS   number of BCD digits (1..8)
//   MAX_VAL  terminal count, binary (1..10^DIGITS-1)
//   DIV      clk cycles per count step (1..2^16)
//
// Ports
//   clk       clock; all state changes on its rising edge
//   rest_n    asynchronous active-low reset
//   start     run request (level)
//   stop      pause request (level); wins over start
//   clr       synchronous clear of the count, returns to IDLE
//   up_dn     1 = count up, 0 = count down
//   load      synchronous load of load_val (any state, no state change)
//   load_val  BCD load value, digit 0 in [3:0]
//   bcd       current count in BCD (the count register itself)
//   seg       active-high {g..a} segments per digit, one cycle behind bcd
//   running   high while in RUN
//   wrap      one-cycle pulse after a wrap-around step
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped, prescaler held at 0, waiting for start
// RUN   | prescaler advancing, count steps on every prescaler tick
// PAUSE | count and prescaler frozen, resumes on start
module bcd_timer_n #(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 99,
    parameter int DIV     = 1
) (
    input  logic                  clk,
    input  logic                  rest_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clr,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  running,
    output logic                  wrap
);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        case (d)
            4'd0:    seg_pat = 7'h3F;
            4'd1:    seg_pat = 7'h06;
            4'd2:    seg_pat = 7'h5B;
            4'd3:    seg_pat = 7'h4F;
            4'd4:    seg_pat = 7'h66;
            4'd5:    seg_pat = 7'h6D;
            4'd6:    seg_pat = 7'h7D;
            4'd7:    seg_pat = 7'h07;
            4'd8:    seg_pat = 7'h7F;
            4'd9:    seg_pat = 7'h6F;
            default: seg_pat = 7'h00;
        endcase
    endfunction

    localparam int                  PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]       PRE_TC   = PW'(DIV - 1);
    localparam logic [4*DIGITS-1:0] MAX_BCD  = to_bcd(MAX_VAL);
    localparam logic [7*DIGITS-1:0] SEG_ZERO = {DIGITS{7'h3F}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                run_nxt;
    logic [PW-1:0]       presc;
    logic                tick;
    logic [4*DIGITS-1:0] cnt;
    logic [4*DIGITS-1:0] cnt_inc;
    logic [4*DIGITS-1:0] cnt_dec;
    logic [31:0]         ld_bin;
    logic                ld_ok;
    logic [7*DIGITS-1:0] seg_nxt;
    logic                cy;
    logic                bw;

    // state register
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // next-state logic; stop has priority over start
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start && !stop) state_nxt = S_RUN;
                S_RUN:   if (stop)           state_nxt = S_PAUSE;
                S_PAUSE: if (start && !stop) state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // output logic; decoded from the next state so running lines up with state
    always_comb begin
        run_nxt = (state_nxt == S_RUN);
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) running <= 1'b0;
        else         running <= run_nxt;
    end

    assign tick = (state == S_RUN) && (presc == PRE_TC);

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n)                                presc <= '0;
        else if (clr || load || state == S_IDLE)    presc <= '0;
        else if (state == S_RUN)                    presc <= tick ? '0 : presc + PW'(1);
    end

    // Ripple carry/borrow across digits. The terminal values (MAX_VAL up,
    // 0 down) are caught separately, so these never see an out-of-range result.
    always_comb begin
        cnt_inc = cnt;
        cnt_dec = cnt;
        cy      = 1'b1;
        bw      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (cnt[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    cy = 1'b0;
                end
            end
            if (bw) begin
                if (cnt[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
                    bw = 1'b0;
                end
            end
        end
    end

    // A load value with a non-decimal digit or above MAX_VAL saturates to MAX_VAL.
    always_comb begin
        ld_bin = '0;
        ld_ok  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            ld_bin = ld_bin * 32'd10 + 32'(load_val[4*i +: 4]);
            if (load_val[4*i +: 4] > 4'd9) ld_ok = 1'b0;
        end
        if (ld_bin > 32'(MAX_VAL)) ld_ok = 1'b0;
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (load) begin
                cnt <= ld_ok ? load_val : MAX_BCD;
            end else if (tick) begin
                if (up_dn) begin
                    if (cnt == MAX_BCD) begin
                        cnt  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else begin
                    if (cnt == '0) begin
                        cnt  <= MAX_BCD;
                        wrap <= 1'b1;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
            end
        end
    end

    assign bcd = cnt;

    always_comb begin
        seg_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_nxt[7*i +: 7] = seg_pat(cnt[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) seg <= SEG_ZERO;
        else         seg <= seg_nxt;
    end

endmodule

// File: tb/tb_bcd_timer_n.sv
// Testbench for bcd_timer_n. Two instances share the inputs:
//   dut_a: DIGITS=2, MAX_VAL=99, DIV=1
//   dut_b: DIGITS=2, MAX_VAL=59, DIV=4
// A behavioural model (integer count, integer prescaler) is compared with both
// instances after every clock edge; directed vectors and sequences add fixed
// expectations on top.
module tb_bcd_timer_n;

    logic        clk = 1'b0;
    logic        rest_n;
    logic        start, stop, clr, up_dn, load;
    logic [7:0]  load_val;
    logic [7:0]  bcd_a, bcd_b;
    logic [13:0] seg_a, seg_b;
    logic        running_a, running_b, wrap_a, wrap_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_timer_n #(.DIGITS(2), .MAX_VAL(99), .DIV(1)) dut_a (
        .clk(clk), .rest_n(rest_n), .start(start), .stop(stop), .clr(clr),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .bcd(bcd_a), .seg(seg_a), .running(running_a), .wrap(wrap_a)
    );

    bcd_timer_n #(.DIGITS(2), .MAX_VAL(59), .DIV(4)) dut_b (
        .clk(clk), .rest_n(rest_n), .start(start), .stop(stop), .clr(clr),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .bcd(bcd_b), .seg(seg_b), .running(running_b), .wrap(wrap_b)
    );

    // ---------------- reference model ----------------
    // state: 0 idle, 1 run, 2 pause
    int m_max [2] = '{99, 59};
    int m_div [2] = '{1, 4};
    int m_state [2];
    int m_cnt [2];
    int m_pre [2];
    int m_seg [2];
    bit m_wrap [2];

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; 9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [13:0] seg14(input int v);
        return {seg7(v / 10), seg7(v % 10)};
    endfunction

    function automatic logic [7:0] to_bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_cnt[k] = 0; m_pre[k] = 0; m_seg[k] = 0; m_wrap[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int s, c, p, hi, lo;
            bit tk, w, valid;
            s  = m_state[k];
            c  = m_cnt[k];
            p  = m_pre[k];
            tk = (s == 1) && (p == m_div[k] - 1);
            w  = 1'b0;
            m_seg[k] = c;
            hi = int'(load_val[7:4]);
            lo = int'(load_val[3:0]);
            valid = (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= m_max[k]);
            if (clr)       c = 0;
            else if (load) c = valid ? hi * 10 + lo : m_max[k];
            else if (tk) begin
                if (up_dn) begin
                    w = (c == m_max[k]);
                    c = (c + 1) % (m_max[k] + 1);
                end else begin
                    w = (c == 0);
                    c = (c == 0) ? m_max[k] : c - 1;
                end
            end
            if (clr || load || s == 0) p = 0;
            else if (s == 1)           p = (p + 1) % m_div[k];
            if (clr)                           s = 0;
            else if (s == 1) begin if (stop)   s = 2; end
            else if (start && !stop)           s = 1;
            m_state[k] = s; m_cnt[k] = c; m_pre[k] = p; m_wrap[k] = w;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model bcd_a",  32'(bcd_a),     32'(to_bcd8(m_cnt[0])));
        chk("model seg_a",  32'(seg_a),     32'(seg14(m_seg[0])));
        chk("model run_a",  32'(running_a), 32'(m_state[0] == 1));
        chk("model wrap_a", 32'(wrap_a),    32'(m_wrap[0]));
        chk("model bcd_b",  32'(bcd_b),     32'(to_bcd8(m_cnt[1])));
        chk("model seg_b",  32'(seg_b),     32'(seg14(m_seg[1])));
        chk("model run_b",  32'(running_b), 32'(m_state[1] == 1));
        chk("model wrap_b", 32'(wrap_b),    32'(m_wrap[1]));
    endtask

    // one clock: model sees the inputs present at the edge, outputs sampled 1ns later
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clr = 0; load = 0; up_dn = 1; load_val = 8'h00;
    endtask

    task automatic do_reset();
        rest_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rest_n = 1'b1;
        chk("reset bcd_a",  32'(bcd_a),     32'h00);
        chk("reset seg_a",  32'(seg_a),     32'h1FBF);
        chk("reset run_a",  32'(running_a), 32'h0);
        chk("reset wrap_a", 32'(wrap_a),    32'h0);
        chk("reset bcd_b",  32'(bcd_b),     32'h00);
    endtask

    typedef struct {
        bit       start, stop, clr, up_dn, load;
        bit [7:0] load_val;
        bit [7:0] e_bcd;
        bit       e_run, e_wrap;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // expectations for dut_a (MAX_VAL=99, DIV=1), starting from reset
        //          st stp clr up ld  val    bcd   run wrap
        tbl[0]  = '{1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0}; // start&stop in IDLE holds
        tbl[1]  = '{1, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0}; // enter RUN
        tbl[2]  = '{0, 0, 0, 1, 0, 8'h00, 8'h01, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 8'h00, 8'h02, 1, 0};
        tbl[4]  = '{0, 1, 0, 1, 0, 8'h00, 8'h03, 0, 0}; // last RUN cycle still steps
        tbl[5]  = '{0, 0, 0, 1, 0, 8'h00, 8'h03, 0, 0}; // PAUSE holds
        tbl[6]  = '{0, 0, 0, 1, 1, 8'h7A, 8'h99, 0, 0}; // invalid digit -> MAX_VAL
        tbl[7]  = '{1, 0, 0, 1, 0, 8'h00, 8'h99, 1, 0}; // resume
        tbl[8]  = '{0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1}; // up wrap
        tbl[9]  = '{0, 0, 0, 1, 0, 8'h00, 8'h01, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0}; // direction change, no skip
        tbl[11] = '{0, 0, 0, 0, 0, 8'h00, 8'h99, 1, 1}; // down wrap
        tbl[12] = '{0, 0, 1, 0, 1, 8'h42, 8'h00, 0, 0}; // clr beats load
        tbl[13] = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 1, 8'h42, 8'h42, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 1, 8'h9F, 8'h99, 0, 0};

        idle_inputs();
        rest_n = 1'b0;
        #12;
        do_reset();

        // ---- vector table ----
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start; stop = tbl[i].stop; clr = tbl[i].clr;
            up_dn = tbl[i].up_dn; load = tbl[i].load; load_val = tbl[i].load_val;
            cyc();
            chk($sformatf("vec%0d bcd_a", i),  32'(bcd_a),     32'(tbl[i].e_bcd));
            chk($sformatf("vec%0d run_a", i),  32'(running_a), 32'(tbl[i].e_run));
            chk($sformatf("vec%0d wrap_a", i), 32'(wrap_a),    32'(tbl[i].e_wrap));
        end

        // ---- full up count with wrap on dut_a ----
        do_reset();
        up_dn = 1; start = 1;
        cyc();
        start = 0;
        cyc();
        chk("up first step bcd_a", 32'(bcd_a), 32'h01);
        chk("up first step run_a", 32'(running_a), 32'h1);
        for (int i = 2; i <= 99; i++) cyc();
        chk("up at max bcd_a", 32'(bcd_a), 32'h99);
        chk("up at max wrap_a", 32'(wrap_a), 32'h0);
        cyc();
        chk("up wrap bcd_a", 32'(bcd_a), 32'h00);
        chk("up wrap pulse", 32'(wrap_a), 32'h1);
        cyc();
        chk("up after wrap bcd_a", 32'(bcd_a), 32'h01);
        chk("up wrap single cycle", 32'(wrap_a), 32'h0);

        // ---- down wrap with DIV=4 on dut_b ----
        do_reset();
        up_dn = 0; load = 1; load_val = 8'h00;
        cyc();
        load = 0; start = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("div4 prescale hold bcd_b", 32'(bcd_b), 32'h00);
        end
        cyc();
        chk("down wrap bcd_b", 32'(bcd_b), 32'h59);
        chk("down wrap pulse", 32'(wrap_b), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("div4 hold bcd_b", 32'(bcd_b), 32'h59);
            chk("down wrap single cycle", 32'(wrap_b), 32'h0);
        end
        cyc();
        chk("down step bcd_b", 32'(bcd_b), 32'h58);
        chk("down step wrap_b", 32'(wrap_b), 32'h0);

        // ---- pause with prescaler at 2, then resume ----
        cyc();
        cyc();
        stop = 1;
        cyc();
        chk("pause run_b", 32'(running_b), 32'h0);
        chk("pause bcd_b", 32'(bcd_b), 32'h58);
        stop = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("paused bcd_b", 32'(bcd_b), 32'h58);
        end
        start = 1;
        cyc();
        chk("resume run_b", 32'(running_b), 32'h1);
        chk("resume no step yet", 32'(bcd_b), 32'h58);
        start = 0;
        cyc();
        chk("resume step bcd_b", 32'(bcd_b), 32'h57);

        // ---- saturating loads and segment lag on dut_b ----
        clr = 1;
        cyc();
        clr = 0; load = 1; load_val = 8'h7A;
        cyc();
        chk("load 7A bcd_b", 32'(bcd_b), 32'h59);
        chk("seg lags load", 32'(seg_b), 32'h1FBF);
        load = 0;
        cyc();
        chk("seg 59 after load 7A", 32'(seg_b), 32'({7'h6D, 7'h6F}));
        load = 1; load_val = 8'h12;
        cyc();
        load_val = 8'h75;
        cyc();
        chk("load 75 bcd_b", 32'(bcd_b), 32'h59);
        chk("load 75 bcd_a", 32'(bcd_a), 32'h75);
        load = 0;
        cyc();
        chk("seg 59 after load 75", 32'(seg_b), 32'({7'h6D, 7'h6F}));

        // ---- asynchronous reset mid-run ----
        up_dn = 1; start = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 5; i++) cyc();
        #2 rest_n = 1'b0;
        #1;
        chk("async rst bcd_a",  32'(bcd_a),     32'h00);
        chk("async rst seg_a",  32'(seg_a),     32'h1FBF);
        chk("async rst run_a",  32'(running_a), 32'h0);
        chk("async rst wrap_a", 32'(wrap_a),    32'h0);
        chk("async rst bcd_b",  32'(bcd_b),     32'h00);
        chk("async rst run_b",  32'(running_b), 32'h0);
        model_reset();
        #1 rest_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("post rst idle bcd_a", 32'(bcd_a), 32'h00);
        chk("post rst idle run_a", 32'(running_a), 32'h0);

        // ---- randomized against the model ----
        for (int it = 0; it < 800; it++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 7) == 0);
            clr      = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = 8'($urandom);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 299) == 0) begin
                #2 rest_n = 1'b0;
                #1 model_reset();
                rest_n = 1'b1;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_timer_n.md
BCD_TIMER_N -- requirements
Module: bcd_timer_n

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, meaning the number of BCD digits (1..8).
REQ-002 The block SHALL have parameter MAX_VAL, default 99, meaning the terminal count (binary integer, 1..10^DIGITS-1).
REQ-003 The block SHALL have parameter DIV, default 1, meaning clk cycles per count step (1..2^16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state changes on its rising edge.
REQ-005 The block SHALL have port rest_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: run request, level sampled each cycle.
REQ-007 The block SHALL have port stop, input, 1 bit: pause request, level sampled each cycle.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear to 0 and IDLE.
REQ-009 The block SHALL have port up_dn, input, 1 bit: 1 = count up, 0 = count down.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-011 The block SHALL have port load_val, input, 4*DIGITS bits: BCD load value, digit 0 in bits [3:0].
REQ-012 The block SHALL have port bcd, output, 4*DIGITS bits: current count in BCD, digit 0 least significant.
REQ-013 The block SHALL have port seg, output, 7*DIGITS bits: active-high segments {g..a} per digit, digit 0 in [6:0].
REQ-014 The block SHALL have port running, output, 1 bit: high while in RUN.
REQ-015 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on wrap-around.

Function
REQ-016 The block SHALL implement states IDLE, RUN and PAUSE with the following transitions.
- IDLE->RUN on start & !stop.
- RUN->PAUSE on stop.
- PAUSE->RUN on start & !stop.
- Any state->IDLE on clr.
- In all other cases the state holds.
REQ-017 When start and stop are both high in the same cycle, stop SHALL win: RUN goes to PAUSE, and IDLE/PAUSE hold.
REQ-018 The prescaler SHALL count 0..DIV-1 only in RUN, SHALL assert an internal tick when at DIV-1 and return to 0, and SHALL hold its value in PAUSE.
- The prescaler is zeroed in IDLE, on clr and on load.
- With DIV=1, tick is asserted every RUN cycle.
REQ-019 On a RUN cycle with tick, the count SHALL step by one in the direction given by up_dn.
- Up: MAX_VAL wraps to 0.
- Down: 0 wraps to MAX_VAL.
REQ-020 The count SHALL be held as per-digit BCD with ripple carry/borrow across digits; no digit SHALL ever hold 10..15.
REQ-021 wrap SHALL be high for exactly the cycle following the edge at which a wrap occurred, and low otherwise.
REQ-022 Priority SHALL be clr > load > count step.
- load SHALL apply in any state, SHALL not change state, and SHALL not raise wrap.
REQ-023 A load_val that contains any digit above 9, or that exceeds MAX_VAL, SHALL load MAX_VAL.
REQ-024 bcd SHALL be the count register itself, with zero added latency.
REQ-025 seg SHALL be registered and SHALL lag bcd by exactly one cycle, using standard 0-9 patterns (0 = 7'h3F, 1 = 7'h06, ..., 9 = 7'h6F).
REQ-026 running SHALL be a registered decode of state == RUN.
REQ-027 Changing up_dn mid-run SHALL take effect at the next tick, with no skipped or duplicated count.

Reset
REQ-028 rest_n low SHALL immediately force the following, independent of clk:
- state IDLE, count 0, prescaler 0;
- bcd 0, running 0, wrap 0;
- seg equal to 7'h3F in every digit.
REQ-029 Deassertion of rest_n SHALL leave the block in IDLE; it SHALL not count until a start is sampled.
REQ-030 Reset asserted mid-RUN SHALL discard the count and prescaler state with no wrap pulse.

Verification
REQ-031 Test: DIGITS=2, MAX_VAL=99, DIV=1, up, start pulse -> bcd reads 8'h01 one cycle later, running=1; after 99 ticks bcd=8'h99; next tick bcd=8'h00 with a single-cycle wrap.
REQ-032 Test: MAX_VAL=59, down, load 8'h00, then start -> next tick bcd=8'h59 with wrap=1; next tick 8'h58 with wrap=0.
REQ-033 Test: DIV=4, RUN, stop asserted when the prescaler is at 2, then start again -> exactly 2 cycles to the next step; bcd is unchanged during PAUSE.
REQ-034 Test: start=stop=1 in IDLE -> stays IDLE. In RUN, clr and load together -> bcd=0, state IDLE.
REQ-035 Test: load_val=8'h7A (invalid) or 8'h75 with MAX_VAL=59 -> bcd=8'h59; seg follows bcd one cycle later with digit patterns 7'h6D and 7'h6F.
REQ-036 Test: rest_n pulsed low mid-RUN between clk edges -> outputs reach reset values before the next edge; after release the block stays IDLE, bcd=0.
